// File: rtl/atm_ports_pkg.sv
// Port constants, decode masks and strobe FSM encoding
// shared by the ATM pager controller.
package atm_ports_pkg;

    localparam logic [15:0] PORT_EFF7   = 16'hEFF7;
    localparam logic [7:0]  PORT_77_LO  = 8'h77;
    localparam logic [7:0]  PORT_F7_LO  = 8'hF7;
    localparam logic [15:0] MASK_7FFD   = 16'h8002;
    localparam logic [15:0] MATCH_7FFD  = 16'h0000;
    localparam logic [7:0]  MASK_F7_HI  = 8'h37;
    localparam logic [7:0]  MATCH_F7_HI = 8'h37;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_END = 2'd2
    } zio_state_e;

    typedef struct packed {
        logic eff7;
        logic p7ffd;
        logic atm;
        logic p77;
    } port_hit_t;

    // One-hot hit vector, earlier ports shadow later ones
    function automatic port_hit_t decode_port(input logic [15:0] a);
        port_hit_t h;
        h = '0;
        if (a == PORT_EFF7)
            h.eff7 = 1'b1;
        else if ((a & MASK_7FFD) == MATCH_7FFD)
            h.p7ffd = 1'b1;
        else if (a[7:0] == PORT_F7_LO && (a[15:8] & MASK_F7_HI) == MATCH_F7_HI)
            h.atm = 1'b1;
        else if (a[7:0] == PORT_77_LO)
            h.p77 = 1'b1;
        return h;
    endfunction

endpackage

// File: rtl/atm_pager_ctrl_if.sv
// Z80 bus as seen after the fclk synchroniser.
interface atm_pager_ctrl_if;

    logic        zpos;
    logic        zneg;
    logic [15:0] za;
    logic [7:0]  zd;
    logic        iorq_n;
    logic        wr_n;
    logic        m1_n;

    modport master (
        output zpos, zneg, za, zd, iorq_n, wr_n, m1_n
    );

    modport slave (
        input zpos, zneg, za, zd, iorq_n, wr_n, m1_n
    );

endinterface

// File: rtl/zio_wr_detect.sv
// Z80 I/O write detector: one strobe per OUT cycle with
// the address/data captured at its first zneg.
module zio_wr_detect
    import atm_ports_pkg::*;
(
    input  logic        fclk,
    input  logic        rst,
    input  logic        i_zneg,
    input  logic [15:0] i_za,
    input  logic [7:0]  i_zd,
    input  logic        i_iorq_n,
    input  logic        i_wr_n,
    input  logic        i_m1_n,
    output logic        o_stb,
    output logic        o_active,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data
);

    zio_state_e  r_state;
    zio_state_e  w_next;
    logic        w_start;
    logic        r_stb;
    logic [15:0] r_addr;
    logic [7:0]  r_data;

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= WAIT_END;
            r_stb   <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_stb   <= w_start;
            if (w_start) begin
                r_addr <= i_za;
                r_data <= i_zd;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        if (i_zneg) begin
            unique case (r_state)
                IDLE: begin
                    if (!i_iorq_n && !i_wr_n && i_m1_n) begin
                        w_next  = ACTIVE;
                        w_start = 1'b1;
                    end
                end
                ACTIVE:   w_next = WAIT_END;
                WAIT_END: if (i_iorq_n) w_next = IDLE;
                default:  w_next = WAIT_END;
            endcase
        end
    end

    assign o_stb    = r_stb;
    assign o_active = (r_state == ACTIVE);
    assign o_addr   = r_addr;
    assign o_data   = r_data;

endmodule

// File: rtl/atm_pager_ctrl.sv
// ATM pager configuration: port decode, Pentagon-1024
// mapping state, pager write strobe and global DOS flag.
module atm_pager_ctrl
    import atm_ports_pkg::*;
#(
    parameter bit ATM_DOS_ONLY = 1'b1,
    parameter bit RST_DOS      = 1'b0
) (
    input  logic             fclk,
    input  logic             rst,
    atm_pager_ctrl_if.slave  zbus,
    input  logic [3:0]       dos_turn_on,
    input  logic [3:0]       dos_turn_off,
    output logic             atmF7_wr,
    output logic             pent1m_ROM,
    output logic [5:0]       pent1m_page,
    output logic             pent1m_ram0_0,
    output logic             pent1m_1m_on,
    output logic             pager_off,
    output logic             dos,
    output logic             lock_7ffd,
    output logic             io_wr_stb
);

    logic        w_stb;
    logic        w_active;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    port_hit_t   w_hit;
    logic        w_atm_ok;
    logic        w_eff7;
    logic        w_7ffd;
    logic        w_atm;
    logic        w_77;

    logic        r_atm_wr;
    logic        r_io_stb;
    logic        r_rom;
    logic [5:0]  r_page;
    logic        r_ram0;
    logic        r_1m_on;
    logic        r_pager_off;
    logic        r_dos;
    logic        r_lock;

    zio_wr_detect u_det (
        .fclk     (fclk),
        .rst      (rst),
        .i_zneg   (zbus.zneg),
        .i_za     (zbus.za),
        .i_zd     (zbus.zd),
        .i_iorq_n (zbus.iorq_n),
        .i_wr_n   (zbus.wr_n),
        .i_m1_n   (zbus.m1_n),
        .o_stb    (w_stb),
        .o_active (w_active),
        .o_addr   (w_addr),
        .o_data   (w_data)
    );

    always_comb begin
        w_hit    = decode_port(w_addr);
        w_atm_ok = !ATM_DOS_ONLY || r_dos || r_pager_off;
        w_eff7   = w_stb && w_hit.eff7;
        w_7ffd   = w_stb && w_hit.p7ffd && !r_lock;
        w_atm    = w_stb && w_active && w_hit.atm && w_atm_ok;
        w_77     = w_stb && w_hit.p77 && w_atm_ok;
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_atm_wr    <= 1'b0;
            r_io_stb    <= 1'b0;
            r_rom       <= 1'b0;
            r_page      <= '0;
            r_ram0      <= 1'b0;
            r_1m_on     <= 1'b1;
            r_pager_off <= 1'b0;
            r_lock      <= 1'b0;
            r_dos       <= RST_DOS;
        end else begin
            r_atm_wr <= w_atm;
            r_io_stb <= w_eff7 || w_7ffd || w_atm || w_77;
            if (w_eff7) begin
                r_1m_on <= ~w_data[2];
                r_ram0  <= w_data[3];
                if (!w_data[2]) r_lock <= 1'b0;
            end
            if (w_7ffd) begin
                r_rom <= w_data[4];
                if (r_1m_on) begin
                    r_page <= {w_data[7:6], w_data[5], w_data[2:0]};
                end else begin
                    r_page <= {3'b000, w_data[2:0]};
                    r_lock <= w_data[5];
                end
            end
            if (w_77) r_pager_off <= ~w_data[3];
            // Turn-on wins over a simultaneous turn-off
            if (|dos_turn_on)
                r_dos <= 1'b1;
            else if (|dos_turn_off)
                r_dos <= 1'b0;
        end
    end

    assign atmF7_wr      = r_atm_wr;
    assign io_wr_stb     = r_io_stb;
    assign pent1m_ROM    = r_rom;
    assign pent1m_page   = r_page;
    assign pent1m_ram0_0 = r_ram0;
    assign pent1m_1m_on  = r_1m_on;
    assign pager_off     = r_pager_off;
    assign dos           = r_dos;
    assign lock_7ffd     = r_lock;

endmodule

// File: tb/tb_atm_pager_ctrl.sv
// Self-checking bench for atm_pager_ctrl: vector table,
// directed corner sequences and random OUTs vs a model.
module tb_atm_pager_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dos_turn_on;
    logic [3:0] dos_turn_off;
    logic       atmF7_wr;
    logic       pent1m_ROM;
    logic [5:0] pent1m_page;
    logic       pent1m_ram0_0;
    logic       pent1m_1m_on;
    logic       pager_off;
    logic       dos;
    logic       lock_7ffd;
    logic       io_wr_stb;

    atm_pager_ctrl_if zbus ();

    atm_pager_ctrl #(.ATM_DOS_ONLY(1'b1), .RST_DOS(1'b0)) dut (
        .fclk          (clk),
        .rst           (rst),
        .zbus          (zbus),
        .dos_turn_on   (dos_turn_on),
        .dos_turn_off  (dos_turn_off),
        .atmF7_wr      (atmF7_wr),
        .pent1m_ROM    (pent1m_ROM),
        .pent1m_page   (pent1m_page),
        .pent1m_ram0_0 (pent1m_ram0_0),
        .pent1m_1m_on  (pent1m_1m_on),
        .pager_off     (pager_off),
        .dos           (dos),
        .lock_7ffd     (lock_7ffd),
        .io_wr_stb     (io_wr_stb)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    logic       m_rom, m_ram0, m_1m, m_poff, m_dos, m_lock;
    logic [5:0] m_page;

    // per-transaction observations
    int   io_cnt, atm_cnt;
    logic lat_io, lat_atm, early_io;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        ack;
        logic [5:0]  page;
        logic        rom;
        logic        on1m;
        logic        lock;
        logic        io;
        logic        atm;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (io_wr_stb) io_cnt++;
        if (atmF7_wr) atm_cnt++;
    endtask

    task automatic zneg_pulse();
        zbus.zneg = 1'b1;
        tick();
        zbus.zneg = 1'b0;
        tick();
    endtask

    function automatic logic [11:0] dut_vec();
        return {pent1m_ROM, pent1m_page, pent1m_ram0_0, pent1m_1m_on,
                pager_off, lock_7ffd, dos};
    endfunction

    function automatic logic [11:0] mdl_vec();
        return {m_rom, m_page, m_ram0, m_1m, m_poff, m_lock, m_dos};
    endfunction

    task automatic model_reset();
        m_rom = 0; m_page = 0; m_ram0 = 0; m_1m = 1;
        m_poff = 0; m_lock = 0; m_dos = 0;
    endtask

    // Map update for one OUT, computed straight from the port rules
    task automatic model_io(input logic [15:0] a, input logic [7:0] d,
                            input logic ack, output logic e_io, output logic e_atm);
        logic ok;
        e_io = 0;
        e_atm = 0;
        ok = m_dos || m_poff;
        if (!ack) begin
            if (a == 16'hEFF7) begin
                m_1m = !d[2];
                m_ram0 = d[3];
                if (!d[2]) m_lock = 0;
                e_io = 1;
            end else if (!a[15] && !a[1]) begin
                if (!m_lock) begin
                    m_rom = d[4];
                    if (m_1m) begin
                        m_page = {d[7:6], d[5], d[2:0]};
                    end else begin
                        m_page = {3'b000, d[2:0]};
                        m_lock = d[5];
                    end
                    e_io = 1;
                end
            end else if (a[7:0] == 8'hF7 && a[13:12] == 2'b11 && a[10:8] == 3'b111) begin
                if (ok) begin
                    e_io = 1;
                    e_atm = 1;
                end
            end else if (a[7:0] == 8'h77) begin
                if (ok) begin
                    m_poff = !d[3];
                    e_io = 1;
                end
            end
        end
    endtask

    // Full Z80 OUT (or INTA when ack=1) cycle
    task automatic do_io(input logic [15:0] a, input logic [7:0] d, input logic ack);
        io_cnt = 0;
        atm_cnt = 0;
        zbus.za = a;
        zbus.zd = d;
        zbus.iorq_n = 1'b0;
        zbus.wr_n = ack;
        zbus.m1_n = !ack;
        zbus.zneg = 1'b1;
        tick();
        zbus.zneg = 1'b0;
        early_io = io_wr_stb;
        tick();
        lat_io = io_wr_stb;
        lat_atm = atmF7_wr;
        tick();
        tick();
        zneg_pulse();
        zbus.iorq_n = 1'b1;
        zbus.wr_n = 1'b1;
        zbus.m1_n = 1'b1;
        tick();
        zneg_pulse();
    endtask

    task automatic io_and_check(input string tag, input logic [15:0] a,
                                input logic [7:0] d, input logic ack);
        logic e_io, e_atm;
        model_io(a, d, ack, e_io, e_atm);
        do_io(a, d, ack);
        chk({tag, "_state"}, 32'(dut_vec()), 32'(mdl_vec()));
        chk({tag, "_io_lat"}, 32'(lat_io), 32'(e_io));
        chk({tag, "_atm_lat"}, 32'(lat_atm), 32'(e_atm));
        chk({tag, "_io_cnt"}, io_cnt, 32'(e_io));
        chk({tag, "_atm_cnt"}, atm_cnt, 32'(e_atm));
    endtask

    task automatic dos_pulse(input logic [3:0] on, input logic [3:0] off);
        dos_turn_on = on;
        dos_turn_off = off;
        if (|on) m_dos = 1;
        else if (|off) m_dos = 0;
        tick();
        dos_turn_on = 4'h0;
        dos_turn_off = 4'h0;
        chk("dos_pulse", 32'(dos), 32'(m_dos));
    endtask

    initial begin
        logic e_io, e_atm;

        vecs[0] = '{16'h7FFD, 8'h17, 1'b0, 6'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'hEFF7, 8'h04, 1'b0, 6'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFD, 8'h20, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFD, 8'h03, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'hEFF7, 8'h00, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFD, 8'hE5, 1'b0, 6'h3D, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h7FFD, 8'h10, 1'b1, 6'h3D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h1FFD, 8'h12, 1'b0, 6'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{16'h7FF7, 8'h40, 1'b0, 6'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'hFE77, 8'h00, 1'b0, 6'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        dos_turn_on = 4'h0;
        dos_turn_off = 4'h0;
        zbus.zpos = 1'b0;
        zbus.zneg = 1'b0;
        zbus.za = 16'h0000;
        zbus.zd = 8'h00;
        zbus.iorq_n = 1'b1;
        zbus.wr_n = 1'b1;
        zbus.m1_n = 1'b1;
        model_reset();
        io_cnt = 0;
        atm_cnt = 0;
        repeat (3) tick();
        chk("reset_state", 32'(dut_vec()), 32'(mdl_vec()));
        chk("reset_strobes", 32'({io_wr_stb, atmF7_wr}), 32'd0);
        rst = 1'b0;
        zneg_pulse();

        // vector table
        for (int i = 0; i < 10; i++) begin
            model_io(vecs[i].a, vecs[i].d, vecs[i].ack, e_io, e_atm);
            do_io(vecs[i].a, vecs[i].d, vecs[i].ack);
            chk($sformatf("v%0d_page", i), 32'(pent1m_page), 32'(vecs[i].page));
            chk($sformatf("v%0d_rom", i), 32'(pent1m_ROM), 32'(vecs[i].rom));
            chk($sformatf("v%0d_1m", i), 32'(pent1m_1m_on), 32'(vecs[i].on1m));
            chk($sformatf("v%0d_lock", i), 32'(lock_7ffd), 32'(vecs[i].lock));
            chk($sformatf("v%0d_early", i), 32'(early_io), 32'd0);
            chk($sformatf("v%0d_io_lat", i), 32'(lat_io), 32'(vecs[i].io));
            chk($sformatf("v%0d_io_cnt", i), io_cnt, 32'(vecs[i].io));
            chk($sformatf("v%0d_atm_cnt", i), atm_cnt, 32'(vecs[i].atm));
        end

        // ATM port becomes writable once DOS is on
        dos_pulse(4'b0001, 4'b0000);
        io_and_check("atm_dos", 16'h7FF7, 8'h40, 1'b0);

        // DOS on/off priority
        dos_pulse(4'b0000, 4'b0010);
        dos_pulse(4'b0100, 4'b0010);
        chk("dos_prio", 32'(dos), 32'd1);
        dos_pulse(4'b0000, 4'b1000);
        chk("dos_off", 32'(dos), 32'd0);

        // reset in the middle of an OUT cycle
        io_cnt = 0;
        atm_cnt = 0;
        zbus.za = 16'h7FFD;
        zbus.zd = 8'h17;
        zbus.iorq_n = 1'b0;
        zbus.wr_n = 1'b0;
        zbus.m1_n = 1'b1;
        zbus.zneg = 1'b1;
        rst = 1'b1;
        tick();
        zbus.zneg = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midrst_state", 32'(dut_vec()), 32'(mdl_vec()));
        zneg_pulse();
        zneg_pulse();
        chk("midrst_state2", 32'(dut_vec()), 32'(mdl_vec()));
        chk("midrst_no_stb", io_cnt + atm_cnt, 32'd0);
        zbus.iorq_n = 1'b1;
        zbus.wr_n = 1'b1;
        tick();
        zneg_pulse();
        dos_pulse(4'b0001, 4'b0000);
        io_and_check("p77", 16'h1277, 8'h00, 1'b0);
        chk("p77_poff", 32'(pager_off), 32'd1);

        // interrupt acknowledge on 7FFD
        io_and_check("inta", 16'h7FFD, 8'h07, 1'b1);

        // random OUTs against the model
        for (int i = 0; i < 300; i++) begin
            logic [15:0] a;
            logic [7:0]  d;
            logic        ack;
            int          k;
            k = $urandom_range(0, 7);
            a = 16'($urandom);
            d = 8'($urandom);
            ack = 1'b0;
            case (k)
                0: a = 16'hEFF7;
                1: a = a & 16'h7FFD;
                2: a = {a[15:14], 2'b11, a[11], 3'b111, 8'hF7};
                3: a = {a[15:8], 8'h77};
                4: ack = 1'b1;
                5: dos_pulse(4'($urandom), 4'($urandom));
                default: ;
            endcase
            if (k == 0 && $urandom_range(0, 1) == 0) d[2] = 1'b0;
            io_and_check($sformatf("rnd%0d", i), a, d, ack);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

endmodule
